axi_stream_remove_header: RTL and testbench

Strips a per-packet header of byte_remove_cnt bytes from the front of an AXI Stream packet. The stripped bytes are presented on a separate header channel. The remaining payload is realigned so that its first byte lands on the MSB lane. It sits on the receive side, mirroring the insert-header path: it undoes the header insertion and hands the header to control logic.

---
 rtl/axis_hdr_pkg.sv | 35 +++
 rtl/axis_reg_slice.sv | 45 ++++
 rtl/axi_stream_remove_header.sv | 152 +++++++++++++++
 tb/tb_axi_stream_remove_header.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-lane helpers for the header-removal path.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    S_CFG,
    S_FIRST,
    S_STREAM,
    S_FLUSH
  } state_e;

  // Upper bound on bytes per beat; callers cast results down to their own width.
  localparam int unsigned MAX_BYTES = 128;

  // Number of set byte enables.
  function automatic int unsigned keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  // Mask with the top cnt lanes of an nbytes-wide beat set (lane nbytes-1 is first).
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int unsigned cnt,
                                                       input int unsigned nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i + cnt >= nbytes)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry registered output slot: holds its word until the consumer takes it.
module axis_reg_slice #(
  parameter int unsigned WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [WD-1:0] data_i,
  output logic          free_o,
  output logic          valid_o,
  output logic [WD-1:0] data_o,
  input  logic          ready_i
);

  logic          valid_q, valid_d;
  logic [WD-1:0] data_q, data_d;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load wins over drain; the producer only loads when the slot is free.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips a per-packet header of byte_remove_cnt bytes and realigns the payload to the MSB lane.
module axi_stream_remove_header
  import axis_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
);

  localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;
  localparam int unsigned PAY_WD = DATA_WD + DATA_BYTE_WD + 1;
  localparam int unsigned HDR_WD = DATA_WD + DATA_BYTE_WD;

  state_e                   state_q, state_d;
  logic [BYTE_CNT_WD-1:0]   n_q, n_d;
  logic [DATA_WD-1:0]       buf_q, buf_d;
  logic [CNT_WD-1:0]        buf_cnt_q, buf_cnt_d;

  logic                     pay_load, pay_free, pay_last;
  logic [DATA_WD-1:0]       pay_data;
  logic [DATA_BYTE_WD-1:0]  pay_keep;
  logic                     hdr_load, hdr_free;
  logic [DATA_BYTE_WD-1:0]  hdr_keep;
  int unsigned              c, n, rem, take;

  // Next state, slot loads and the combinational ready decodes.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    buf_d        = buf_q;
    buf_cnt_d    = buf_cnt_q;
    ready_remove = 1'b0;
    ready_in     = 1'b0;
    pay_load     = 1'b0;
    pay_data     = '0;
    pay_keep     = '0;
    pay_last     = 1'b0;
    hdr_load     = 1'b0;
    hdr_keep     = '0;
    c            = keep_to_cnt(MAX_BYTES'(keep_in));
    n            = 32'(n_q);
    rem          = (c > n) ? c - n : 0;
    take         = (c < n) ? c : n;

    case (state_q)
      S_CFG: begin
        ready_remove = 1'b1;
        if (valid_remove) begin
          n_d     = byte_remove_cnt;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        ready_in = hdr_free;
        if (valid_in && hdr_free) begin
          hdr_load  = (n != 0);
          hdr_keep  = DATA_BYTE_WD'(cnt_to_keep(n, DATA_BYTE_WD)) & keep_in;
          buf_d     = data_in << (8 * n);
          buf_cnt_d = CNT_WD'(rem);
          state_d   = last_in ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        ready_in = pay_free;
        if (valid_in && pay_free) begin
          pay_load  = 1'b1;
          // The spill term is gated for N=0 instead of relying on a full-width shift.
          pay_data  = buf_q | ((n == 0) ? '0 : (data_in >> (8 * (DATA_BYTE_WD - n))));
          pay_keep  = DATA_BYTE_WD'(cnt_to_keep(32'(buf_cnt_q) + take, DATA_BYTE_WD));
          buf_d     = data_in << (8 * n);
          buf_cnt_d = CNT_WD'(rem);
          if (last_in) begin
            if (c <= n) begin
              pay_last = 1'b1;
              state_d  = S_CFG;
            end else begin
              state_d  = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (pay_free) begin
          pay_load = 1'b1;
          pay_data = buf_q;
          pay_keep = DATA_BYTE_WD'(cnt_to_keep(32'(buf_cnt_q), DATA_BYTE_WD));
          pay_last = 1'b1;
          state_d  = S_CFG;
        end
      end
      default: state_d = S_CFG;
    endcase
  end

  // Control and realignment registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CFG;
      n_q       <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  axis_reg_slice #(.WD(PAY_WD)) u_pay_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (pay_load),
    .data_i  ({pay_data, pay_keep, pay_last}),
    .free_o  (pay_free),
    .valid_o (valid_out),
    .data_o  ({data_out, keep_out, last_out}),
    .ready_i (ready_out)
  );

  axis_reg_slice #(.WD(HDR_WD)) u_hdr_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hdr_load),
    .data_i  ({data_in, hdr_keep}),
    .free_o  (hdr_free),
    .valid_o (valid_header),
    .data_o  ({data_header, keep_header}),
    .ready_i (ready_header)
  );

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Bench for axi_stream_remove_header with W=4: directed table, stall/reset sequences, random packets.
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_remove;
  logic [1:0]  byte_remove_cnt;
  logic        ready_remove;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        ready_header;

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_remove    (valid_remove),
    .byte_remove_cnt (byte_remove_cnt),
    .ready_remove    (ready_remove),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_header    (valid_header),
    .data_header     (data_header),
    .keep_header     (keep_header),
    .ready_header    (ready_header)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } hdr_t;

  typedef struct {
    int               n;
    int               nb;
    logic [3:0][31:0] din;
    logic [3:0][3:0]  kin;
    int               nout;
    logic [3:0][31:0] dout;
    logic [3:0][3:0]  kout;
    int               nhdr;
    logic [31:0]      hd;
    logic [3:0]       hk;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  hdr_t  hgot_q[$];
  hdr_t  hexp_q[$];

  int passed = 0;
  int total  = 0;
  int ro_mode = 0;
  int rh_mode = 0;
  int hdr_block = 0;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Output-side consumer: drives readies, records handshakes, checks hold-while-stalled.
  initial begin
    logic  out_stalled, hdr_stalled;
    beat_t out_prev;
    hdr_t  hdr_prev;
    out_stalled = 1'b0;
    hdr_stalled = 1'b0;
    out_prev = '0;
    hdr_prev = '0;
    ready_out = 1'b1;
    ready_header = 1'b1;
    forever begin
      @(negedge clk);
      case (ro_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = ~ready_out;
        default: ready_out = ($urandom_range(0, 9) < 7);
      endcase
      if (hdr_block > 0) begin
        ready_header = 1'b0;
        if (valid_header) hdr_block--;
      end else begin
        ready_header = (rh_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      #4;
      if (out_stalled) begin
        chk("out_hold_valid", 64'(valid_out), 64'd1);
        chk("out_hold_beat", 64'({data_out, keep_out, last_out}), 64'(out_prev));
      end
      if (hdr_stalled) begin
        chk("hdr_hold_valid", 64'(valid_header), 64'd1);
        chk("hdr_hold_beat", 64'({data_header, keep_header}), 64'(hdr_prev));
      end
      if (valid_out && ready_out) got_q.push_back({data_out, keep_out, last_out});
      if (valid_header && ready_header) hgot_q.push_back({data_header, keep_header});
      out_stalled = valid_out && !ready_out;
      out_prev    = {data_out, keep_out, last_out};
      hdr_stalled = valid_header && !ready_header;
      hdr_prev    = {data_header, keep_header};
    end
  end

  // Sends a removal count and then up to stop_at beats of the packet.
  task automatic send_pkt(input int n, input int nb, input logic [7:0][31:0] d,
                          input logic [7:0][3:0] k, input int stop_at);
    bit hs;
    int guard;
    hs = 0;
    guard = 0;
    while (!hs && guard < 300) begin
      @(negedge clk);
      valid_remove = 1'b1;
      byte_remove_cnt = 2'(n);
      valid_in = 1'b0;
      #4;
      hs = ready_remove;
      guard++;
    end
    if (!hs) chk("cfg_handshake_timeout", 64'd0, 64'd1);
    for (int i = 0; i < nb && i < stop_at; i++) begin
      hs = 0;
      guard = 0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        valid_remove = 1'b0;
        valid_in = 1'b1;
        data_in = d[i];
        keep_in = k[i];
        last_in = (i == nb - 1);
        #4;
        hs = ready_in;
        guard++;
      end
      if (!hs) chk("beat_handshake_timeout", 64'd0, 64'd1);
      if (hs && i == 0) chk("b0_hdr_slot_free", 64'(!valid_header || ready_header), 64'd1);
    end
    @(negedge clk);
    valid_remove = 1'b0;
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  // Reference: strip N bytes from the packet's byte string, rechunk MSB-first into W-byte beats.
  task automatic model_pkt(input int n, input int nb, input logic [7:0][31:0] d,
                           input logic [7:0][3:0] k);
    logic [7:0] bytes[$];
    beat_t      b;
    logic [3:0] m;
    for (int i = 0; i < nb; i++)
      for (int lane = 3; lane >= 0; lane--)
        if (k[i][lane]) bytes.push_back(d[i][lane*8 +: 8]);
    if (n > 0) begin
      m = 4'hF << (4 - n);
      hexp_q.push_back({d[0], m & k[0]});
    end
    for (int i = 0; i < n && bytes.size() > 0; i++) void'(bytes.pop_front());
    if (bytes.size() == 0) begin
      exp_q.push_back({32'h0, 4'h0, 1'b1});
    end else begin
      while (bytes.size() > 0) begin
        b = '0;
        for (int lane = 3; lane >= 0; lane--) begin
          if (bytes.size() > 0) begin
            b.d[lane*8 +: 8] = bytes.pop_front();
            b.k[lane] = 1'b1;
          end
        end
        b.l = (bytes.size() == 0);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_for(input int nout, input int nhdr);
    int cyc;
    cyc = 0;
    while ((got_q.size() < nout || hgot_q.size() < nhdr) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic compare_all(input string tag);
    wait_for(exp_q.size(), hexp_q.size());
    chk({tag, "_out_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, "_hdr_count"}, 64'(hgot_q.size()), 64'(hexp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_out_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    for (int i = 0; i < hexp_q.size() && i < hgot_q.size(); i++)
      chk({tag, "_hdr_beat"}, 64'(hgot_q[i]), 64'(hexp_q[i]));
    got_q.delete(); exp_q.delete(); hgot_q.delete(); hexp_q.delete();
  endtask

  task automatic apply_vec(input int idx);
    logic [7:0][31:0] d;
    logic [7:0][3:0]  k;
    string            tag;
    d = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      d[i] = vt[idx].din[i];
      k[i] = vt[idx].kin[i];
    end
    tag = $sformatf("vec%0d", idx);
    send_pkt(vt[idx].n, vt[idx].nb, d, k, vt[idx].nb);
    wait_for(vt[idx].nout, vt[idx].nhdr);
    chk({tag, "_out_count"}, 64'(got_q.size()), 64'(vt[idx].nout));
    chk({tag, "_hdr_count"}, 64'(hgot_q.size()), 64'(vt[idx].nhdr));
    for (int j = 0; j < vt[idx].nout && j < got_q.size(); j++) begin
      chk({tag, "_data"}, 64'(got_q[j].d), 64'(vt[idx].dout[j]));
      chk({tag, "_keep"}, 64'(got_q[j].k), 64'(vt[idx].kout[j]));
      chk({tag, "_last"}, 64'(got_q[j].l), 64'(j == vt[idx].nout - 1));
    end
    if (vt[idx].nhdr == 1 && hgot_q.size() > 0) begin
      chk({tag, "_hdr_data"}, 64'(hgot_q[0].d), 64'(vt[idx].hd));
      chk({tag, "_hdr_keep"}, 64'(hgot_q[0].k), 64'(vt[idx].hk));
    end
    got_q.delete(); hgot_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][31:0] d;
    logic [7:0][3:0]  k;
    int               n, nb, c;

    vt[0] = '{n: 1, nb: 2, din: {32'h0, 32'h0, 32'h11223344, 32'hAABBCCDD},
              kin: {4'h0, 4'h0, 4'hF, 4'hF}, nout: 2,
              dout: {32'h0, 32'h0, 32'h22334400, 32'hBBCCDD11}, kout: {4'h0, 4'h0, 4'hE, 4'hF},
              nhdr: 1, hd: 32'hAABBCCDD, hk: 4'h8};
    vt[1] = '{n: 2, nb: 2, din: {32'h0, 32'h0, 32'h11220000, 32'hAABBCCDD},
              kin: {4'h0, 4'h0, 4'hC, 4'hF}, nout: 1,
              dout: {32'h0, 32'h0, 32'h0, 32'hCCDD1122}, kout: {4'h0, 4'h0, 4'h0, 4'hF},
              nhdr: 1, hd: 32'hAABBCCDD, hk: 4'hC};
    vt[2] = '{n: 0, nb: 3, din: {32'h0, 32'h090A0B0C, 32'h05060708, 32'h01020304},
              kin: {4'h0, 4'hF, 4'hF, 4'hF}, nout: 3,
              dout: {32'h0, 32'h090A0B0C, 32'h05060708, 32'h01020304}, kout: {4'h0, 4'hF, 4'hF, 4'hF},
              nhdr: 0, hd: 32'h0, hk: 4'h0};
    vt[3] = '{n: 3, nb: 1, din: {32'h0, 32'h0, 32'h0, 32'hAABBCCDD},
              kin: {4'h0, 4'h0, 4'h0, 4'hF}, nout: 1,
              dout: {32'h0, 32'h0, 32'h0, 32'hDD000000}, kout: {4'h0, 4'h0, 4'h0, 4'h8},
              nhdr: 1, hd: 32'hAABBCCDD, hk: 4'hE};
    vt[4] = '{n: 2, nb: 1, din: {32'h0, 32'h0, 32'h0, 32'h11220000},
              kin: {4'h0, 4'h0, 4'h0, 4'hC}, nout: 1,
              dout: {32'h0, 32'h0, 32'h0, 32'h0}, kout: {4'h0, 4'h0, 4'h0, 4'h0},
              nhdr: 1, hd: 32'h11220000, hk: 4'hC};
    vt[5] = '{n: 3, nb: 2, din: {32'h0, 32'h0, 32'hEE000000, 32'hAABBCCDD},
              kin: {4'h0, 4'h0, 4'h8, 4'hF}, nout: 1,
              dout: {32'h0, 32'h0, 32'h0, 32'hDDEE0000}, kout: {4'h0, 4'h0, 4'h0, 4'hC},
              nhdr: 1, hd: 32'hAABBCCDD, hk: 4'hE};

    rst_n = 1'b0;
    valid_remove = 1'b0;
    byte_remove_cnt = '0;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_valid_header", 64'(valid_header), 64'd0);
    chk("rst_out_beat", 64'({data_out, keep_out, last_out}), 64'd0);
    chk("rst_hdr_beat", 64'({data_header, keep_header}), 64'd0);
    chk("rst_ready_remove", 64'(ready_remove), 64'd1);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) apply_vec(v);

    // Alternating downstream ready and a header held off for five valid cycles.
    ro_mode = 1;
    hdr_block = 5;
    d = '0;
    k = '0;
    d[0] = 32'hAABBCCDD; d[1] = 32'h11223344; k[0] = 4'hF; k[1] = 4'hF;
    for (int p = 0; p < 2; p++) begin
      model_pkt(1, 2, d, k);
      send_pkt(1, 2, d, k, 2);
      d[0] = 32'h55667788; d[1] = 32'h99AA0000; k[1] = 4'hC;
    end
    compare_all("stall");
    ro_mode = 0;

    // Reset in the middle of a packet, then a clean packet.
    d = '0;
    k = '0;
    d[0] = 32'hAABBCCDD; d[1] = 32'h11223344; k[0] = 4'hF; k[1] = 4'hF;
    send_pkt(1, 2, d, k, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_valid_header", 64'(valid_header), 64'd0);
    chk("midrst_ready_remove", 64'(ready_remove), 64'd1);
    chk("midrst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete(); hgot_q.delete();
    apply_vec(0);

    // Random packets against the reference model with random backpressure on both channels.
    ro_mode = 2;
    rh_mode = 1;
    for (int p = 0; p < 40; p++) begin
      n  = $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      d = '0;
      k = '0;
      for (int i = 0; i < nb; i++) begin
        c = (i == nb - 1) ? $urandom_range(1, 4) : 4;
        k[i] = 4'hF << (4 - c);
        d[i] = $urandom & {{8{k[i][3]}}, {8{k[i][2]}}, {8{k[i][1]}}, {8{k[i][0]}}};
      end
      model_pkt(n, nb, d, k);
      send_pkt(n, nb, d, k, nb);
    end
    compare_all("rand");
    ro_mode = 0;
    rh_mode = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
